// File: rtl/isp_regbank_pkg.sv
// Register map, reset defaults and write-protection mask for the ISP control register bank.
package isp_regbank_pkg;

    localparam int unsigned REG_W        = 16;
    localparam int unsigned NUM_DEF_REGS = 16;
    localparam int unsigned DEF_IDX_W    = 4;

    localparam int unsigned ADDR_ISP_IN_PIXEL_X  = 0;
    localparam int unsigned ADDR_ISP_IN_PIXEL_Y  = 1;
    localparam int unsigned ADDR_CROP_X0         = 2;
    localparam int unsigned ADDR_CROP_Y0         = 3;
    localparam int unsigned ADDR_CROP_W          = 4;
    localparam int unsigned ADDR_CROP_H          = 5;
    localparam int unsigned ADDR_GAIN_R          = 6;
    localparam int unsigned ADDR_GAIN_G          = 7;
    localparam int unsigned ADDR_GAIN_B          = 8;
    localparam int unsigned ADDR_DPC_THRESH      = 9;
    localparam int unsigned ADDR_HSV_HUE_OFS     = 10;
    localparam int unsigned ADDR_HSV_SAT_OFS     = 11;
    localparam int unsigned ADDR_HSV_VAL_OFS     = 12;
    localparam int unsigned ADDR_STATUS          = 13;
    localparam int unsigned ADDR_CHIP_ID         = 14;
    localparam int unsigned ADDR_NATURE_SAT_GAIN = 15;

    localparam logic [REG_W-1:0] DEFAULT_REGS [NUM_DEF_REGS] = '{
        16'h0280, 16'h01E0, 16'h0000, 16'h0000,
        16'h0280, 16'h01E0, 16'h0100, 16'h0100,
        16'h0100, 16'h0040, 16'h0000, 16'h0000,
        16'h0000, 16'h0001, 16'h15A1, 16'h0100
    };

    // STATUS (13) and CHIP_ID (14) are read-only when protection is enabled.
    localparam logic [NUM_DEF_REGS-1:0] WRITABLE_MASK = 16'h9FFF;

    typedef enum logic {ST_IDLE, ST_PENDING} commit_state_e;

    function automatic logic [REG_W-1:0] default_reg(input int unsigned idx);
        if (idx < NUM_DEF_REGS) return DEFAULT_REGS[idx[DEF_IDX_W-1:0]];
        return '0;
    endfunction

    function automatic logic is_writable(input int unsigned idx);
        if (idx < NUM_DEF_REGS) return WRITABLE_MASK[idx[DEF_IDX_W-1:0]];
        return 1'b1;
    endfunction

endpackage

// File: rtl/isp_regbank_rdport.sv
// Registered readback mux: selects staging or active copy, returns 0 for out-of-range addresses.
module isp_regbank_rdport
    import isp_regbank_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_sel,
    input  logic [DATA_W-1:0] staging [NUM_REGS],
    input  logic [DATA_W-1:0] active  [NUM_REGS],
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              in_range;
    logic [IDX_W-1:0]  rd_idx;

    assign in_range = (32'(rd_addr) < NUM_REGS);
    assign rd_idx   = rd_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                if (!in_range)   rd_data_q <= '0;
                else if (rd_sel) rd_data_q <= active[rd_idx];
                else             rd_data_q <= staging[rd_idx];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/isp_regbank_shadow.sv
// Double-buffered ISP register bank: host writes go to staging, copied to active at frame start.
// Optional build macro ISP_REGBANK_WR_MASK_EN rejects writes to registers cleared in WRITABLE_MASK.
module isp_regbank_shadow
    import isp_regbank_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              frame_start,
    input  logic              force_commit,
    output logic              wr_err,
    output logic              commit_done,
    output logic              pending,
    output logic [DATA_W-1:0] active_regs [NUM_REGS]
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] staging_q [NUM_REGS];
    logic [DATA_W-1:0] active_q  [NUM_REGS];
    commit_state_e     state_q;
    logic              wr_err_q;
    logic              commit_done_q;

    logic             wr_allowed;
    logic             wr_ok;
    logic             do_commit;
    logic [IDX_W-1:0] wr_idx;

`ifdef ISP_REGBANK_WR_MASK_EN
    assign wr_allowed = is_writable(32'(wr_addr));
`else
    assign wr_allowed = 1'b1;
`endif

    assign wr_idx    = wr_addr[IDX_W-1:0];
    assign wr_ok     = wr_en && (32'(wr_addr) < NUM_REGS) && wr_allowed;
    assign do_commit = (frame_start || force_commit) && (state_q == ST_PENDING);

    // Commit copies the pre-edge staging, so a same-cycle write stays pending for the next trigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                staging_q[i] <= DATA_W'(default_reg(i));
                active_q[i]  <= DATA_W'(default_reg(i));
            end
            state_q       <= ST_IDLE;
            wr_err_q      <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            wr_err_q      <= wr_en && !wr_ok;
            commit_done_q <= do_commit;
            if (do_commit) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    active_q[i] <= staging_q[i];
                end
            end
            if (wr_ok) begin
                staging_q[wr_idx] <= wr_data;
            end
            case (state_q)
                ST_IDLE:    if (wr_ok) state_q <= ST_PENDING;
                ST_PENDING: if (do_commit && !wr_ok) state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    isp_regbank_rdport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rdport (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_sel   (rd_sel),
        .staging  (staging_q),
        .active   (active_q),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    assign wr_err      = wr_err_q;
    assign commit_done = commit_done_q;
    assign pending     = (state_q == ST_PENDING);
    assign active_regs = active_q;

endmodule
